// File: rtl/beverage_sequencer.sv
// beverage_sequencer: debounced front-panel drink sequencer with per-recipe stage masks
// Buttons are synchronised, debounced and edge-detected before reaching the IDLE/RUN/DONE FSM.
module beverage_sequencer #(
    parameter int NUM_RECIPES = 3,
    parameter int NUM_STAGES = 6,
    parameter int TICK_DIV = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter logic [4*NUM_STAGES-1:0] STAGE_TICKS = {6{4'd2}},
    parameter logic [NUM_RECIPES*NUM_STAGES-1:0] RECIPE_MASK = 18'b010101_101011_111111,
    parameter int DONE_TICKS = 4,
    localparam int RW = $clog2(NUM_RECIPES),
    localparam int SW = $clog2(NUM_STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          next_n,
    input  logic          select_n,
    input  logic          cancel_n,
    output logic [RW-1:0] recipe,
    output logic [SW-1:0] stage,
    output logic          busy,
    output logic          done,
    output logic          abort
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TDW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int TW = DONE_TICKS > 31 ? $clog2(DONE_TICKS + 1) : 5;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state;
    logic [2:0] sync1, sync2, level, ev;
    logic [2:0][DW-1:0] cnt;
    logic [TDW-1:0] tdiv;
    logic [TW-1:0] tcnt, limit;
    logic [NUM_STAGES-1:0] mask;
    logic [3:0] raw_ticks;
    logic tick, last, has_nxt;
    int sidx, nxt;
    // synchronisers idle high so a released button reads as not pressed out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '0;
            ev <= '0;
            cnt <= '0;
        end else begin
            sync1 <= {cancel_n, select_n, next_n};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                ev[i] <= 1'b0;
                if (~sync2[i] == level[i]) cnt[i] <= '0;
                else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    level[i] <= ~level[i];
                    ev[i] <= ~level[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    always_comb begin
        mask = RECIPE_MASK[int'(recipe)*NUM_STAGES +: NUM_STAGES];
        sidx = stage == '0 ? 0 : int'(stage) - 1;
        raw_ticks = STAGE_TICKS[sidx*4 +: 4];
        limit = state == S_DONE ? TW'(DONE_TICKS) : TW'(raw_ticks == 4'd0 ? 4'd1 : raw_ticks);
        tick = tdiv == TDW'(TICK_DIV - 1);
        last = tick && tcnt == limit - TW'(1);
        nxt = 0;
        has_nxt = 1'b0;
        // lowest set stage at or above the 1-based stage value, i.e. strictly after the current one
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (mask[j] && j >= int'(stage)) begin
                nxt = j;
                has_nxt = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            recipe <= '0;
            stage <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            abort <= 1'b0;
            tdiv <= '0;
            tcnt <= '0;
        end else begin
            abort <= 1'b0;
            tdiv <= tick ? '0 : tdiv + 1'b1;
            tcnt <= tick ? tcnt + 1'b1 : tcnt;
            if (state == S_IDLE) begin
                if (ev[0]) recipe <= recipe == RW'(NUM_RECIPES - 1) ? '0 : recipe + 1'b1;
                if (ev[1]) begin
                    tdiv <= '0;
                    tcnt <= '0;
                    state <= has_nxt ? S_RUN : S_DONE;
                    busy <= has_nxt;
                    done <= ~has_nxt;
                    stage <= has_nxt ? SW'(nxt + 1) : '0;
                end
            end else if (state == S_RUN && ev[2]) begin
                state <= S_IDLE;
                busy <= 1'b0;
                stage <= '0;
                abort <= 1'b1;
                tdiv <= '0;
                tcnt <= '0;
            end else if (last) begin
                tdiv <= '0;
                tcnt <= '0;
                if (state == S_RUN && has_nxt) stage <= SW'(nxt + 1);
                else if (state == S_RUN) begin
                    state <= S_DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    stage <= '0;
                end else begin
                    state <= S_IDLE;
                    done <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/beverage_sequencer.md
# beverage_sequencer

Parametrised drink-preparation sequencer that replaces the fixed three-recipe, six-stage coffee controller. It debounces the front-panel buttons and cycles through `NUM_RECIPES` recipes. Each run steps through a per-recipe subset of `NUM_STAGES` stages, each with its own duration, and a run can be cancelled. It sits between the raw board buttons and the display decoders and LED animation; its `recipe`, `stage` and `done` outputs drive those blocks directly.

## Interface
- `NUM_RECIPES`, 3, number of selectable recipes (≥2).
- `NUM_STAGES`, 6, number of process stages (≥1).
- `TICK_DIV`, 4, clk cycles per stage tick (≥1); use 4 in simulation and the board value in synthesis.
- `DEBOUNCE_CYCLES`, 3, consecutive stable synchronised samples before a button level is accepted (≥1).
- `STAGE_TICKS`, {6{4'd2}}, 4 bits per stage, stage s at [4s+3:4s]; a value of 0 is treated as 1.
- `RECIPE_MASK`, 18'b010101_101011_111111, NUM_STAGES bits per recipe; bit r*NUM_STAGES+s set means recipe r executes stage s.
- `DONE_TICKS`, 4, ticks spent in DONE before returning to IDLE (≥1).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `next_n`  in  1  "next recipe" button, active-low, asynchronous.
- `select_n`  in  1  "start" button, active-low, asynchronous.
- `cancel_n`  in  1  "cancel" button, active-low, asynchronous.
- `recipe`  out  $clog2(NUM_RECIPES)  currently selected recipe index.
- `stage`  out  $clog2(NUM_STAGES+1)  0 = no stage active, s+1 = stage s active.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `abort`  out  1  one-cycle pulse when a run is cancelled.

## Operation
- Button path, identical for each button: 2-flop synchroniser → inversion to a pressed level → debounce counter. The accepted level changes only after `DEBOUNCE_CYCLES` consecutive samples disagree with it. A 0→1 change of the accepted level produces a one-cycle event (`ev_next`, `ev_sel`, `ev_cancel`). Holding a button produces exactly one event.
- Recipe register: wraps from NUM_RECIPES-1 to 0 on `ev_next`. It updates only in IDLE; `ev_next` is ignored in RUN and DONE.
- Tick counter: counts 0..TICK_DIV-1 and raises `tick` on TICK_DIV-1. It is cleared on every FSM state or stage change, so each stage lasts exactly max(STAGE_TICKS[s],1)·TICK_DIV cycles.
- FSM states: IDLE, RUN, DONE.
  - IDLE, on `ev_sel`:
    - If the mask for `recipe` is non-zero, go to RUN at the lowest set stage.
    - If the mask is all zero, go to DONE.
  - RUN: a stage tick-counter counts ticks. When the count reaches the stage duration, advance to the next higher set stage in the mask. If there is none, go to DONE.
  - RUN with `ev_cancel`: go to IDLE and pulse `abort`. Cancel has priority over stage advance in the same cycle.
  - DONE: after DONE_TICKS ticks, go to IDLE. `ev_sel` and `ev_cancel` are ignored in DONE.
- `ev_sel` in RUN is ignored. `ev_cancel` in IDLE is ignored and does not pulse `abort`.
- If `ev_next` and `ev_sel` occur in the same IDLE cycle, start with the old `recipe` value; `recipe` increments in the same cycle.

## Timing
- Reset values: `recipe`=0, `stage`=0, `busy`=0, `done`=0, `abort`=0. The synchroniser, debounce state (accepted level = released), tick counter and FSM (IDLE) are all cleared.
- Pin-to-event latency: the event is asserted 2 + DEBOUNCE_CYCLES cycles after the first cycle a press is stable at the pin. With default parameters this is 5 cycles.
- Event-to-output latency: all registered outputs reflect an event on the cycle after the event.
- `abort` is high for exactly the one cycle in which `stage` first reads 0 after the cancel.
- Reset asserted mid-run: all outputs go to their reset values immediately (asynchronous). No `abort` pulse is produced.

## Test plan
- Reset, then press `next_n` four times, each held for 10 cycles → `recipe` reads 1, 2, 0, 1. A press glitch of 2 cycles causes no change.
- Recipe 0, press `select_n` → `stage` reads 1,2,3,4,5,6, each held 8 cycles. `busy`=1 throughout. Then `done`=1 for 16 cycles, then IDLE with `stage`=0.
- Recipe 1 (mask 101011), start → `stage` sequence 1,2,4,6. Recipe 2 (mask 010101), start → `stage` sequence 1,3,5.
- Start recipe 0, press `cancel_n` during stage 3 → one cycle after the cancel event, `stage`=0, `busy`=0 and `abort`=1 for one cycle. `done` never asserts.
- `next_n` pressed during RUN → `recipe` unchanged. `select_n` pressed during RUN or DONE → the sequence is not restarted.
- Assert `reset` for 1 cycle during stage 4 → all outputs 0 in the same cycle. A subsequent start runs a full, correct sequence.
